// File: rtl/cmp4_sweep_driver_if.sv
// Control/status bundle of the 4-bit comparator sweep driver.
// master: the board-test controller issuing start and reading results.
// slave:  the sweep driver itself.
interface cmp4_sweep_driver_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic       fail_seen;
  logic [8:0] err_cnt;
  logic [7:0] first_fail;

  modport master (output start,
                  input  busy, done, pass, fail_seen, err_cnt, first_fail);
  modport slave  (input  start,
                  output busy, done, pass, fail_seen, err_cnt, first_fail);
endinterface

// File: rtl/cmp4_sweep_driver.sv
// Exhaustive self-checking sweep of a 4-bit magnitude comparator.
// Applies all 256 {A,B} pairs, samples g/l/e SETTLE cycles after each drive,
// and reports error count, first failing vector and pass/fail.
// Optional build macro: CMP4_SWEEP_STOP_ON_FAIL_EN -- end the sweep at the
// first mismatch and leave the failing vector on the operand pins.
module cmp4_sweep_driver #(
  parameter int SETTLE = 1  // 1..15
) (
  input  logic               clk,
  input  logic               rst,
  cmp4_sweep_driver_if.slave ctl,
  input  logic               g,
  input  logic               l,
  input  logic               e,
  output logic               a1,
  output logic               a2,
  output logic               a3,
  output logic               a4,
  output logic               b1,
  output logic               b2,
  output logic               b3,
  output logic               b4
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [7:0] idx;
  logic [3:0] tmr;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic       fail_q;
  logic [8:0] err_q;
  logic [7:0] first_q;

  logic [2:0] ref_gle;
  logic       mismatch;
  logic [8:0] err_nxt;
  logic       last;
  logic       sample;

  // The operand pins are the vector index itself: A in the high nibble.
  assign {a4, a3, a2, a1} = idx[7:4];
  assign {b4, b3, b2, b1} = idx[3:0];

  assign ctl.busy       = busy_q;
  assign ctl.done       = done_q;
  assign ctl.pass       = pass_q;
  assign ctl.fail_seen  = fail_q;
  assign ctl.err_cnt    = err_q;
  assign ctl.first_fail = first_q;

  // Reference flags for the vector currently on the pins and the sweep-end test.
  always_comb begin
    ref_gle  = {idx[7:4] < idx[3:0], idx[7:4] > idx[3:0], idx[7:4] == idx[3:0]};
    mismatch = ({g, l, e} != ref_gle);
    err_nxt  = err_q + {8'd0, mismatch};
    sample   = (tmr == SETTLE_LAST);
`ifdef CMP4_SWEEP_STOP_ON_FAIL_EN
    last     = (idx == 8'hFF) || mismatch;
`else
    last     = (idx == 8'hFF);
`endif
  end

  // Sweep FSM; all outputs registered, done is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      tmr     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      first_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (ctl.start) begin
            state   <= RUN;
            idx     <= '0;
            tmr     <= '0;
            busy_q  <= 1'b1;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
          end
        end
        RUN: begin
          // start is ignored here; only the settle timer drives progress
          if (sample) begin
            tmr   <= '0;
            err_q <= err_nxt;
            if (mismatch && !fail_q) begin
              fail_q  <= 1'b1;
              first_q <= idx;
            end
            if (last) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              pass_q <= (err_nxt == 9'd0);
            end else begin
              idx <= idx + 8'd1;
            end
          end else begin
            tmr <= tmr + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp4_sweep_driver.sv
// Bench for cmp4_sweep_driver: two instances (SETTLE=1 and a slower one)
// each wired to a behavioural comparator with selectable fault modes.
module tb_cmp4_sweep_driver;

`ifdef CMP4_SWEEP_STOP_ON_FAIL_EN
  localparam int S1 = 2;
`else
  localparam int S1 = 3;
`endif
  localparam int S0 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st  = 1'b0;
  int   sel = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  // comparator fault modes: 0 ideal, 1 e stuck 0, 2 g/l swapped, 3 random e flips
  int           mode0 = 0, mode1 = 0;
  logic [255:0] mask0 = '0, mask1 = '0;

  always #5 clk = ~clk;

  cmp4_sweep_driver_if c0 ();
  cmp4_sweep_driver_if c1 ();

  wire [3:0] pa0, pb0, pa1, pb1;
  wire       g0, l0, e0, g1, l1, e1;

  function automatic logic [2:0] cmp_model(int mode, logic [3:0] a, logic [3:0] b, logic f);
    logic [2:0] r;
    r = {a < b, a > b, a == b};  // {g,l,e}
    case (mode)
      1: r[0] = 1'b0;
      2: r = {r[1], r[2], r[0]};
      3: r[0] = r[0] ^ f;
      default: ;
    endcase
    return r;
  endfunction

  assign {g0, l0, e0} = cmp_model(mode0, pa0, pb0, mask0[{pa0, pb0}]);
  assign {g1, l1, e1} = cmp_model(mode1, pa1, pb1, mask1[{pa1, pb1}]);
  assign c0.start = st && (sel == 0);
  assign c1.start = st && (sel == 1);

  cmp4_sweep_driver #(.SETTLE(S0)) u_dut0 (
    .clk(clk), .rst(rst), .ctl(c0), .g(g0), .l(l0), .e(e0),
    .a1(pa0[0]), .a2(pa0[1]), .a3(pa0[2]), .a4(pa0[3]),
    .b1(pb0[0]), .b2(pb0[1]), .b3(pb0[2]), .b4(pb0[3]));

  cmp4_sweep_driver #(.SETTLE(S1)) u_dut1 (
    .clk(clk), .rst(rst), .ctl(c1), .g(g1), .l(l1), .e(e1),
    .a1(pa1[0]), .a2(pa1[1]), .a3(pa1[2]), .a4(pa1[3]),
    .b1(pb1[0]), .b2(pb1[1]), .b3(pb1[2]), .b4(pb1[3]));

  wire       o_busy  = (sel == 1) ? c1.busy       : c0.busy;
  wire       o_done  = (sel == 1) ? c1.done       : c0.done;
  wire       o_pass  = (sel == 1) ? c1.pass       : c0.pass;
  wire       o_fail  = (sel == 1) ? c1.fail_seen  : c0.fail_seen;
  wire [8:0] o_err   = (sel == 1) ? c1.err_cnt    : c0.err_cnt;
  wire [7:0] o_first = (sel == 1) ? c1.first_fail : c0.first_fail;
  wire [7:0] o_pins  = (sel == 1) ? {pa1, pb1}    : {pa0, pb0};

  // Reference: walk all vectors, compare the comparator model against the ideal rule.
  task automatic ref_sweep(input int mode, input logic [255:0] mask, input int s,
                           output int err, output int first, output int cyc, output int last);
    logic [3:0] a, b;
    logic [2:0] want, got;
    err = 0; first = -1; cyc = 256 * s; last = 255;
    for (int k = 0; k < 256; k++) begin
      a = 4'(k / 16);
      b = 4'(k % 16);
      want = {a < b, a > b, a == b};
      got  = cmp_model(mode, a, b, mask[k]);
      if (want !== got) begin
        err++;
        if (first < 0) first = k;
`ifdef CMP4_SWEEP_STOP_ON_FAIL_EN
        cyc = (k + 1) * s;
        last = k;
        break;
`endif
      end
    end
  endtask

  // Pulse start after a random idle gap and wait for done (cyc = -1 on timeout).
  task automatic run_sweep(output int cyc, output logic busy_t0);
    repeat ($urandom_range(0, 4)) @(posedge clk);
    @(negedge clk); st = 1'b1;
    @(posedge clk); #1; st = 1'b0;
    busy_t0 = o_busy;
    cyc = -1;
    for (int n = 1; n <= 4000; n++) begin
      @(posedge clk); #1;
      if (o_done) begin cyc = n; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 0; st = 1'b1;  // start alongside reset must be dropped
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({c0.busy, c0.done, c0.pass, c0.fail_seen, c0.err_cnt, c0.first_fail, pa0, pb0} !== 30'd0) begin
      n_bad++; $display("FAIL reset_inst0 got busy=%b err=%0d pins=%h want all 0", c0.busy, c0.err_cnt, {pa0, pb0});
    end
    n_cmp++;
    if ({c1.busy, c1.done, c1.pass, c1.fail_seen, c1.err_cnt, c1.first_fail, pa1, pb1} !== 30'd0) begin
      n_bad++; $display("FAIL reset_inst1 got busy=%b err=%0d pins=%h want all 0", c1.busy, c1.err_cnt, {pa1, pb1});
    end
    @(negedge clk); st = 1'b0; rst = 1'b0;
  endtask

  // Full sweep against a given comparator model; all results checked against the reference.
  task automatic test_sweep(input string nm, input int s_sel, input int mode);
    int e_err, e_first, e_cyc, e_last, cyc;
    logic b0;
    logic [255:0] m;
    m = '0;
    if (mode == 3) for (int k = 0; k < 256; k++) m[k] = ($urandom_range(0, 15) == 0);
    sel = s_sel;
    if (s_sel == 1) begin mode1 = mode; mask1 = m; end
    else            begin mode0 = mode; mask0 = m; end
    ref_sweep(mode, m, (s_sel == 1) ? S1 : S0, e_err, e_first, e_cyc, e_last);
    run_sweep(cyc, b0);
    n_cmp++; if (b0 !== 1'b1) begin n_bad++; $display("FAIL %s busy_at_start got %b want 1", nm, b0); end
    n_cmp++; if (cyc != e_cyc) begin n_bad++; $display("FAIL %s done_cycle got %0d want %0d", nm, cyc, e_cyc); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL %s busy_at_done got %b want 0", nm, o_busy); end
`ifdef CMP4_SWEEP_STOP_ON_FAIL_EN
    if (e_err > 1) e_err = 1;
`endif
    n_cmp++; if (o_err !== 9'(e_err)) begin n_bad++; $display("FAIL %s err_cnt got %0d want %0d", nm, o_err, e_err); end
    n_cmp++; if (o_first !== 8'((e_first < 0) ? 0 : e_first)) begin n_bad++; $display("FAIL %s first_fail got %h want %h", nm, o_first, e_first); end
    n_cmp++; if (o_fail !== (e_err > 0)) begin n_bad++; $display("FAIL %s fail_seen got %b want %b", nm, o_fail, e_err > 0); end
    n_cmp++; if (o_pass !== (e_err == 0)) begin n_bad++; $display("FAIL %s pass got %b want %b", nm, o_pass, e_err == 0); end
    n_cmp++; if (o_pins !== 8'(e_last)) begin n_bad++; $display("FAIL %s pins got %h want %h", nm, o_pins, e_last); end
    @(posedge clk); #1;
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL %s done_width got %b want 0", nm, o_done); end
    n_cmp++; if (o_err !== 9'(e_err)) begin n_bad++; $display("FAIL %s err_hold got %0d want %0d", nm, o_err, e_err); end
    mode0 = 0; mode1 = 0;
  endtask

  // A start during RUN is ignored; exactly one done at 256*SETTLE.
  task automatic test_restart_ignored();
    int ndone, first_done;
    sel = 1; mode1 = 0; ndone = 0; first_done = -1;
    @(negedge clk); st = 1'b1;
    @(posedge clk); #1; st = 1'b0;
    for (int n = 1; n <= 256 * S1 + 20; n++) begin
      if (n == 100) st = 1'b1;
      @(posedge clk); #1; st = 1'b0;
      if (o_done) begin ndone++; if (first_done < 0) first_done = n; end
    end
    n_cmp++; if (ndone != 1) begin n_bad++; $display("FAIL restart done_count got %0d want 1", ndone); end
    n_cmp++; if (first_done != 256 * S1) begin n_bad++; $display("FAIL restart done_cycle got %0d want %0d", first_done, 256 * S1); end
    n_cmp++; if ({o_pass, o_fail, o_err} !== {2'b10, 9'd0}) begin n_bad++; $display("FAIL restart result got pass=%b fs=%b err=%0d want 1/0/0", o_pass, o_fail, o_err); end
  endtask

  // Reset at idx=100 clears everything with no done; a new sweep then passes.
  task automatic test_midsweep_reset();
    int ndone, cyc;
    logic b0;
    sel = 0; mode0 = 0; ndone = 0;
    @(negedge clk); st = 1'b1;
    @(posedge clk); #1; st = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (o_done) ndone++;
    end
    n_cmp++; if (o_pins !== 8'd100) begin n_bad++; $display("FAIL midrst idx got %0d want 100", o_pins); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    if (o_done) ndone++;
    n_cmp++;
    if ({o_busy, o_done, o_pass, o_fail, o_err, o_first, o_pins} !== 29'd0) begin
      n_bad++; $display("FAIL midrst outputs got busy=%b err=%0d pins=%h want all 0", o_busy, o_err, o_pins);
    end
    @(negedge clk); rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (o_done) ndone++; end
    n_cmp++; if (ndone != 0) begin n_bad++; $display("FAIL midrst no_done got %0d want 0", ndone); end
    run_sweep(cyc, b0);
    n_cmp++; if (cyc != 256 || o_pass !== 1'b1) begin n_bad++; $display("FAIL midrst rerun got cyc=%0d pass=%b want 256/1", cyc, o_pass); end
  endtask

  // start in the cycle done is high: new sweep begins, done drops.
  task automatic test_back_to_back();
    int cyc;
    logic b0;
    sel = 0; mode0 = 0;
    run_sweep(cyc, b0);
    n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL b2b done_high got %b want 1", o_done); end
    st = 1'b1;
    @(posedge clk); #1; st = 1'b0;
    n_cmp++;
    if ({o_done, o_busy, o_pins, o_pass} !== {2'b01, 8'h00, 1'b0}) begin
      n_bad++; $display("FAIL b2b restart got done=%b busy=%b pins=%h pass=%b want 0/1/00/0", o_done, o_busy, o_pins, o_pass);
    end
    cyc = -1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      if (o_done) begin cyc = n; break; end
    end
    n_cmp++; if (cyc != 256) begin n_bad++; $display("FAIL b2b second_done got %0d want 256", cyc); end
  endtask

  initial begin
    test_reset();
    test_sweep("ideal_s1", 0, 0);
    test_sweep("e_stuck_s1", 0, 1);
    test_sweep("swapped_s1", 0, 2);
    test_sweep("swapped_slow", 1, 2);
    test_sweep("random_s1", 0, 3);
    test_sweep("random_slow", 1, 3);
    test_sweep("ideal_slow", 1, 0);
    test_restart_ignored();
    test_midsweep_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cmp4_sweep_driver.md
# cmp4_sweep_driver

Self-checking driver for the team's 4-bit magnitude comparator (operands `a1..a4`, `b1..b4`; flags `g`/`l`/`e`). On a `start` pulse it applies all 256 operand pairs to the comparator, samples the flags after a programmable settle time and checks them against an internal reference. It reports an error count, the first failing vector and pass/fail. It sits on the board-test path, wired directly to the comparator's ports.

## Interface
Parameters:
- `SETTLE`, default 1: cycles from driving a vector to sampling its flags; legal range 1–15.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: single-cycle request to begin a sweep.
- `g` in 1: comparator flag; 1 when B > A.
- `l` in 1: comparator flag; 1 when A > B.
- `e` in 1: comparator flag; 1 when A == B.
- `a1`..`a4` out 1 each: operand A; `a1` is the LSB, `a4` the MSB.
- `b1`..`b4` out 1 each: operand B; `b1` is the LSB, `b4` the MSB.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when a sweep ends.
- `pass` out 1: last sweep finished with zero errors.
- `fail_seen` out 1: at least one mismatch in the current or last sweep.
- `err_cnt` out 9: number of mismatching vectors, 0–256.
- `first_fail` out 8: index `{A,B}` of the first mismatch.

## Operation
- States:
  - IDLE: reset state.
  - RUN: sweeping.
  - DONE: results held.
- Vector index `idx[7:0]`:
  - A = `idx[7:4]`, B = `idx[3:0]`.
  - Order is 0x00 up to 0xFF, incrementing by 1.
- Reference flags: e = (A==B), l = (A>B), g = (A<B).
- A vector mismatches if any of the three sampled flags differs from its reference flag.
- On each mismatch:
  - `err_cnt` increments.
  - If this is the first mismatch of the sweep, `first_fail` <= idx and `fail_seen` <= 1.
- Transitions:
  - IDLE/DONE + `start` -> RUN. `err_cnt`, `fail_seen`, `first_fail` and `pass` are cleared; idx <= 0; operands are driven to 0.
  - RUN: after the sample of idx 0xFF -> DONE. `done` pulses, `busy` <= 0, `pass` <= (final `err_cnt` == 0).
  - DONE holds all results until the next `start`.
- `start` while in RUN is ignored.
- `err_cnt` never wraps: the maximum is 256, which fits in 9 bits.

## Timing
- Reset values: every output 0 (`a*`, `b*`, `busy`, `done`, `pass`, `fail_seen`, `err_cnt`, `first_fail`); state IDLE; idx 0.
- Start acceptance: `start` is sampled at edge t0. From that edge, `busy`=1 and vector 0 is on the operand pins.
- Sampling: vector k is on the pins from edge t0 + k·SETTLE. Its flags are sampled at edge t0 + (k+1)·SETTLE.
- At that same sample edge, vector k+1 is driven.
- Sweep throughput is one vector per SETTLE cycles.
- The last sample is at t0 + 256·SETTLE. `done` is high for the following cycle only, and `busy` is low from that edge.
- The comparator is combinational, so SETTLE=1 is legal.
- After the sweep, the operand pins hold vector 0xFF.
- `err_cnt`, `fail_seen` and `first_fail` update at the sample edge of the vector concerned.
- `rst` mid-sweep: at the next edge everything returns to reset values. No `done` pulse is produced and partial results are lost.
- `rst` and `start` in the same cycle: reset wins and `start` is dropped.
- `start` in DONE in the same cycle `done` is high: the new sweep starts and `done` still deasserts next cycle.

## Configuration
- `CMP4_SWEEP_STOP_ON_FAIL_EN`:
  - Defined: the first mismatch terminates the sweep at its sample edge. The FSM goes to DONE, `done` pulses next cycle, `err_cnt`=1, `pass`=0, and the operand pins keep holding the failing vector for probing.
  - Undefined: the full 256-vector sweep always runs and every mismatch is counted.

## Test plan
- Ideal comparator model, SETTLE=1, `start` at t0 -> `done` in the cycle after edge t0+256; `pass`=1, `err_cnt`=0, `fail_seen`=0, pins hold A=0xF, B=0xF.
- Model with `e` stuck at 0 -> `err_cnt`=16, `first_fail`=0x00, `fail_seen`=1, `pass`=0.
- Model with `g`/`l` swapped -> `err_cnt`=240, `first_fail`=0x01.
- SETTLE=3, second `start` pulse issued at t0+100 -> ignored; single `done` in the cycle after edge t0+768; results identical to the ideal case.
- `rst` asserted while idx=100 -> next cycle all outputs 0, no `done`; a following `start` completes a passing sweep.
- With `CMP4_SWEEP_STOP_ON_FAIL_EN` and the swapped model, SETTLE=2 -> sample at t0+4, `done` next cycle, `err_cnt`=1, `first_fail`=0x01, pins hold A=0, B=1.
